// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment display between two
// requesters, with a minimum per-grant hold time and frame retention.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   req_a/b    level requests, held until the matching ack
//   data_a/b   packed frames, digit k at [k*ANCHO +: ANCHO]
//   ack_a/b    one-cycle pulse when that source's frame is latched
//   dis_data   registered frame driving Dis0..Dis7
//   active_src 00 none, 01 A, 10 B
//   busy       high while the current frame is being held
module display_arbiter #(
  parameter int ANCHO       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CW          = $clog2(HOLD_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic [8*ANCHO-1:0] data_a,
  input  logic               req_b,
  input  logic [8*ANCHO-1:0] data_b,
  output logic               ack_a,
  output logic               ack_b,
  output logic [8*ANCHO-1:0] dis_data,
  output logic [1:0]         active_src,
  output logic               busy
);

  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nx;
  logic               r_last_b;
  logic               w_last_b_nx;
  logic [8*ANCHO-1:0] r_dis;
  logic [8*ANCHO-1:0] w_dis_nx;
  logic [1:0]         r_src;
  logic [1:0]         w_src_nx;
  logic               r_ack_a;
  logic               w_ack_a_nx;
  logic               r_ack_b;
  logic               w_ack_b_nx;
  logic               r_busy;
  logic               w_busy_nx;
  logic               w_gnt_a;
  logic               w_gnt_b;

  // On a tie the source that did not win last time gets the display.
  assign w_gnt_a = req_a & (~req_b | r_last_b);
  assign w_gnt_b = req_b & ~w_gnt_a;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_last_b_nx = r_last_b;
    w_dis_nx    = r_dis;
    w_src_nx    = r_src;
    w_ack_a_nx  = 1'b0;
    w_ack_b_nx  = 1'b0;
    w_busy_nx   = r_busy;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_a | w_gnt_b) begin
          w_state_nx  = HOLD;
          w_cnt_nx    = LOAD;
          w_busy_nx   = 1'b1;
          w_last_b_nx = w_gnt_b;
          w_ack_a_nx  = w_gnt_a;
          w_ack_b_nx  = w_gnt_b;
          w_dis_nx    = w_gnt_a ? data_a : data_b;
          w_src_nx    = w_gnt_a ? 2'b01 : 2'b10;
        end
      end
      HOLD: begin
        // Leaving on a zero count keeps the counter from wrapping.
        if (r_cnt == '0) begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_b <= 1'b1;
      r_dis    <= '0;
      r_src    <= 2'b00;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_last_b <= w_last_b_nx;
      r_dis    <= w_dis_nx;
      r_src    <= w_src_nx;
      r_ack_a  <= w_ack_a_nx;
      r_ack_b  <= w_ack_b_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign dis_data   = r_dis;
  assign active_src = r_src;
  assign busy       = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: scoreboard of expected grants
// popped on every ack, plus direct timing checks.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [31:0] data_a, data_b;
  logic        ack_a, ack_b, busy;
  logic [31:0] dis;
  logic [1:0]  src;

  logic        rst1;
  logic        req_a1, req_b1;
  logic [31:0] data_a1, data_b1;
  logic        ack_a1, ack_b1, busy1;
  logic [31:0] dis1;
  logic [1:0]  src1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [33:0] sb[$];
  int          ack_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_arbiter #(.ANCHO(4), .HOLD_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .dis_data(dis), .active_src(src), .busy(busy)
  );

  display_arbiter #(.ANCHO(4), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst1),
    .req_a(req_a1), .data_a(data_a1),
    .req_b(req_b1), .data_b(data_b1),
    .ack_a(ack_a1), .ack_b(ack_b1),
    .dis_data(dis1), .active_src(src1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [31:0] d);
    sb.push_back({s, d});
  endtask

  // Scoreboard side: every ack must match the oldest expected grant.
  always @(negedge clk) begin
    logic [33:0] e;
    logic [1:0]  as;
    if (ack_a || ack_b) begin
      as = ack_a ? 2'b01 : 2'b10;
      if (ack_a && ack_b) chk("dual_ack", 1, 0);
      if (sb.size() == 0) begin
        chk("unexp_ack", {as, dis}, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_src", as, e[33:32]);
        chk("sb_active", src, e[33:32]);
        chk("sb_data", dis, e[31:0]);
        ack_t.push_back(cyc);
      end
    end
  end

  initial begin
    int n;
    bit got;
    rst = 1'b0; req_a = 1'b1; req_b = 1'b0;
    data_a = 32'h1234_5678; data_b = 32'h0;
    rst1 = 1'b0; req_a1 = 1'b1; req_b1 = 1'b0;
    data_a1 = 32'h0F0F_0F0F; data_b1 = 32'hFFFF_FFFF;

    // Reset with A requesting
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_dis", dis, 0);
      chk("rst_ack", ack_a, 0);
      chk("rst_src", src, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b1;
    push(2'b01, 32'h1234_5678);
    step();
    chk("first_ack_a", ack_a, 1);
    chk("first_busy", busy, 1);
    req_a = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) chk("ack_pulse", ack_a, 0);
      if (busy) n++;
      else break;
    end
    chk("hold_len", n, 4);
    chk("idle_dis", dis, 32'h1234_5678);
    chk("idle_src", src, 2'b01);
    step();
    chk("idle_dis2", dis, 32'h1234_5678);
    chk("idle_ack", ack_a | ack_b, 0);

    // Tie after reset: A,B,A,B every 5 cycles
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    data_a = 32'hAAAA_AAAA; data_b = 32'hBBBB_BBBB;
    push(2'b01, 32'hAAAA_AAAA);
    push(2'b10, 32'hBBBB_BBBB);
    push(2'b01, 32'hAAAA_AAAA);
    push(2'b10, 32'hBBBB_BBBB);
    ack_t.delete();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack_a | ack_b) n++;
      if (n == 4) break;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("tie_acks", n, 4);
    step();
    chk("tie_times", ack_t.size(), 4);
    if (ack_t.size() >= 4)
      for (int k = 1; k < 4; k++)
        chk("tie_period", ack_t[k] - ack_t[k-1], 5);

    // Request arriving during a hold
    req_a = 1'b1; data_a = 32'h1111_1111;
    push(2'b01, 32'h1111_1111);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_a) begin got = 1'b1; break; end
    end
    chk("t4_ack_a", got, 1);
    req_a = 1'b0;
    req_b = 1'b1; data_b = 32'hCAFE_F00D;
    push(2'b10, 32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_no_ackb", ack_b, 0);
      if (!busy) break;
    end
    step();
    chk("t4_ack_b", ack_b, 1);
    chk("t4_dis", dis, 32'hCAFE_F00D);
    chk("t4_src", src, 2'b10);
    req_b = 1'b0;

    // Reset in the middle of the hold
    step();
    rst = 1'b0;
    step();
    chk("t5_busy", busy, 0);
    chk("t5_dis", dis, 0);
    chk("t5_src", src, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_dis", dis, 0);
      chk("t5_idle_src", src, 0);
      chk("t5_idle_ack", ack_a | ack_b, 0);
    end

    // Data changes during a hold are ignored
    req_a = 1'b1; data_a = 32'h5A5A_5A5A;
    push(2'b01, 32'h5A5A_5A5A);
    step();
    chk("t6_ack", ack_a, 1);
    req_a = 1'b0; data_a = 32'h0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_hold_dis", dis, 32'h5A5A_5A5A);
      if (!busy) break;
    end
    step();
    chk("t6_idle_dis", dis, 32'h5A5A_5A5A);
    chk("t6_idle_ack", ack_a | ack_b, 0);

    // HOLD_CYCLES=2: A re-granted every 3 cycles
    rst1 = 1'b1;
    ack_t.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("h2_no_ackb", ack_b1, 0);
      if (ack_a1) begin
        ack_t.push_back(cyc);
        chk("h2_dis", dis1, 32'h0F0F_0F0F);
        chk("h2_src", src1, 2'b01);
      end
    end
    chk("h2_acks", ack_t.size(), 4);
    if (ack_t.size() >= 2)
      for (int k = 1; k < ack_t.size(); k++)
        chk("h2_period", ack_t[k] - ack_t[k-1], 3);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
